// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the RAM copy/fill engine.
//   ram_copy_mode_t  - command mode (COPY reads a source range, FILL writes a pattern)
//   ram_copy_state_t - engine FSM states
//   wrap_inc         - address increment modulo the RAM depth
package ram_pkg;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } ram_copy_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ram_copy_state_t;

    // Next address after 'addr' in a RAM of 'depth' words; DEPTH-1 wraps to 0.
    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/ram_copy_engine_if.sv
// ram_copy_engine_if: valid/ready read and write ports between the copy engine and a `ram`.
//   master - engine side: drives requests, addresses and write data
//   slave  - RAM side: drives ready strobes and read data
// Read data is valid in the same cycle read_ready is high.
interface ram_copy_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             read_vaild;
    logic             read_ready;
    logic [AW-1:0]    read_address;
    logic [WIDTH-1:0] read_data;

    logic             write_vaild;
    logic             write_ready;
    logic [AW-1:0]    write_address;
    logic [WIDTH-1:0] write_data;

    modport master (
        output read_vaild,
        output read_address,
        input  read_ready,
        input  read_data,
        output write_vaild,
        output write_address,
        output write_data,
        input  write_ready
    );

    modport slave (
        input  read_vaild,
        input  read_address,
        output read_ready,
        output read_data,
        input  write_vaild,
        input  write_address,
        input  write_data,
        output write_ready
    );

endinterface

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: moves a block of words inside one RAM instance on a single command.
//   COPY: reads source_address.. and writes destination_address.. in ascending order.
//   FILL: writes fill_data to destination_address..
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   start, mode            - command strobe (ignored while busy) and COPY/FILL select
//   source_address,
//   destination_address    - first source / destination word (both wrap modulo DEPTH)
//   length                 - word count, values above DEPTH are clamped to DEPTH
//   fill_data              - FILL pattern
//   abort                  - level; stops the command after the current write beat
//   busy, done, aborted    - status; done pulses one cycle, aborted valid with done
//   count                  - words written in the current / last command
//   mem_bus                - read/write request ports to the RAM (master side)
// All outputs are registered.
module ram_copy_engine
    import ram_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             start,
    input  logic             mode,
    input  logic [AW-1:0]    source_address,
    input  logic [AW-1:0]    destination_address,
    input  logic [AW:0]      length,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             abort,

    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [AW:0]      count,

    ram_copy_engine_if.master mem_bus
);

    localparam logic [AW:0] LenMax = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LenOne = (AW + 1)'(1);

    ram_copy_state_t state;
    ram_copy_mode_t  mode_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [AW:0]     remaining_q;
    // Abort seen during a READ; honoured once the word already read is written.
    logic            abort_q;

    logic [AW:0]     len_clamped;
    logic [AW-1:0]   src_next;
    logic [AW-1:0]   dst_next;
    ram_copy_mode_t  mode_in;

    always_comb begin
        len_clamped = (length > LenMax) ? LenMax : length;
        src_next    = AW'(wrap_inc(32'(src_q), DEPTH));
        dst_next    = AW'(wrap_inc(32'(dst_q), DEPTH));
        mode_in     = ram_copy_mode_t'(mode);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            mode_q                <= COPY;
            src_q                 <= '0;
            dst_q                 <= '0;
            remaining_q           <= '0;
            abort_q               <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            aborted               <= 1'b0;
            count                 <= '0;
            mem_bus.read_vaild    <= 1'b0;
            mem_bus.read_address  <= '0;
            mem_bus.write_vaild   <= 1'b0;
            mem_bus.write_address <= '0;
            mem_bus.write_data    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q      <= mode_in;
                        src_q       <= source_address;
                        dst_q       <= destination_address;
                        remaining_q <= len_clamped;
                        count       <= '0;
                        aborted     <= 1'b0;
                        abort_q     <= 1'b0;
                        busy        <= 1'b1;
                        if (len_clamped == '0) begin
                            state <= DONE;
                        end else if (mode_in == FILL) begin
                            // write_data doubles as the data register.
                            mem_bus.write_vaild   <= 1'b1;
                            mem_bus.write_address <= destination_address;
                            mem_bus.write_data    <= fill_data;
                            state                 <= WRITE;
                        end else begin
                            mem_bus.read_vaild   <= 1'b1;
                            mem_bus.read_address <= source_address;
                            state                <= READ;
                        end
                    end
                end

                READ: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (mem_bus.read_ready) begin
                        mem_bus.read_vaild    <= 1'b0;
                        mem_bus.write_data    <= mem_bus.read_data;
                        mem_bus.write_vaild   <= 1'b1;
                        mem_bus.write_address <= dst_q;
                        state                 <= WRITE;
                    end
                end

                WRITE: begin
                    if (mem_bus.write_ready) begin
                        count       <= count + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        src_q       <= src_next;
                        dst_q       <= dst_next;
                        if (remaining_q == LenOne) begin
                            // Last word wins over a late abort: the command completed.
                            abort_q             <= 1'b0;
                            mem_bus.write_vaild <= 1'b0;
                            state               <= DONE;
                        end else if (abort || abort_q) begin
                            abort_q             <= 1'b1;
                            mem_bus.write_vaild <= 1'b0;
                            state               <= DONE;
                        end else if (mode_q == FILL) begin
                            mem_bus.write_address <= dst_next;
                        end else begin
                            mem_bus.write_vaild  <= 1'b0;
                            mem_bus.read_vaild   <= 1'b1;
                            mem_bus.read_address <= src_next;
                            state                <= READ;
                        end
                    end
                end

                DONE: begin
                    // Registered outputs: the done pulse is visible the cycle after DONE.
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    aborted <= abort_q;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] src_a = '0;
    logic [2:0] dst_a = '0;
    logic [3:0] length = '0;
    logic [7:0] fill_data = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] count;

    always #5 clock = ~clock;

    ram_copy_engine_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ram_copy_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .mode                (mode),
        .source_address      (src_a),
        .destination_address (dst_a),
        .length              (length),
        .fill_data           (fill_data),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .aborted             (aborted),
        .count               (count),
        .mem_bus             (bus)
    );

    int total = 0;
    int bad = 0;

    // Behavioural RAM with programmable wait states per beat.
    logic [7:0] mem [DEPTH];
    logic [7:0] load_img [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       load_en = 1'b0;
    logic       log_clear = 1'b0;
    int         wait_cycles = 0;
    int         rd_wait = 0;
    int         wr_wait = 0;
    int         wr_n = 0;
    logic [2:0] wr_addr_log [64];
    int         viol = 0;

    assign bus.read_ready  = bus.read_vaild && (rd_wait >= wait_cycles);
    assign bus.write_ready = bus.write_vaild && (wr_wait >= wait_cycles);
    assign bus.read_data   = mem[bus.read_address];

    always @(posedge clock) begin
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= load_img[i];
        end else if (bus.write_vaild && bus.write_ready) begin
            mem[bus.write_address] <= bus.write_data;
        end
        if (log_clear) begin
            wr_n <= 0;
        end else if (bus.write_vaild && bus.write_ready) begin
            if (wr_n < 64) wr_addr_log[wr_n] <= bus.write_address;
            wr_n <= wr_n + 1;
        end
        rd_wait <= (bus.read_vaild && !bus.read_ready) ? rd_wait + 1 : 0;
        wr_wait <= (bus.write_vaild && !bus.write_ready) ? wr_wait + 1 : 0;
    end

    // Stability monitor: a stalled request must hold vaild/address/data.
    logic       p_rd = 1'b0;
    logic       p_wr = 1'b0;
    logic [2:0] p_ra = '0;
    logic [2:0] p_wa = '0;
    logic [7:0] p_wd = '0;

    always @(posedge clock) begin
        if (reset) begin
            if ((p_rd && (!bus.read_vaild || bus.read_address != p_ra)) ||
                (p_wr && (!bus.write_vaild || bus.write_address != p_wa ||
                          bus.write_data != p_wd)))
                viol <= viol + 1;
        end
        p_rd <= reset && bus.read_vaild && !bus.read_ready;
        p_wr <= reset && bus.write_vaild && !bus.write_ready;
        p_ra <= bus.read_address;
        p_wa <= bus.write_address;
        p_wd <= bus.write_data;
    end

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // kind 0: base+i, kind 1: random
    task automatic preload(input int kind, input int base);
        @(negedge clock);
        for (int i = 0; i < DEPTH; i++) begin
            load_img[i] = (kind == 0) ? 8'(base + i) : 8'($urandom_range(0, 255));
            ref_mem[i]  = load_img[i];
        end
        load_en = 1'b1;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    // Reference: words land in ascending order, each COPY read sees earlier writes.
    task automatic model_cmd(input logic m, input int s, input int d, input int len,
                             input logic [7:0] f, input int limit, output int n_written);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        if (limit >= 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++)
            ref_mem[(d + i) % DEPTH] = m ? f : ref_mem[(s + i) % DEPTH];
        n_written = n;
    endtask

    // Issues one command and waits (bounded) for done. Cycle 1 is the first sample after
    // the edge that accepted start. abort is pulsed in the abort_read-th read-vaild cycle;
    // a second start with different operands is pulsed at cycle restart_at.
    task automatic run_cmd(input logic m, input int s, input int d, input int len,
                           input logic [7:0] f, input int abort_read, input int restart_at,
                           output int cycles, output int wv, output int rv,
                           output logic busy_at_done, output logic done_after,
                           output logic timed_out);
        int rdc;
        @(negedge clock);
        log_clear = 1'b1;
        start     = 1'b1;
        mode      = m;
        src_a     = 3'(s);
        dst_a     = 3'(d);
        length    = 4'(len);
        fill_data = f;
        @(negedge clock);
        start = 1'b0;
        log_clear = 1'b0;
        cycles = 0; wv = 0; rv = 0; rdc = 0;
        busy_at_done = 1'bx; done_after = 1'bx; timed_out = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) @(negedge clock);
            cycles = k + 1;
            abort = 1'b0;
            start = 1'b0;
            if (cycles == restart_at) begin
                start     = 1'b1;
                mode      = 1'b1;
                src_a     = 3'd0;
                dst_a     = 3'd0;
                length    = 4'd8;
                fill_data = 8'hFF;
            end
            if (bus.write_vaild) wv++;
            if (bus.read_vaild) begin
                rv++;
                rdc++;
                if (rdc == abort_read) abort = 1'b1;
            end
            if (done) begin
                timed_out = 1'b0;
                busy_at_done = busy;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (!timed_out) begin
            @(negedge clock);
            done_after = done;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, aborted, count, bus.read_vaild, bus.write_vaild, bus.read_address,
             bus.write_address, bus.write_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b aborted=%b count=%0d rv=%b wv=%b ra=%0d wa=%0d wd=%h required all 0",
                     busy, done, aborted, count, bus.read_vaild, bus.write_vaild,
                     bus.read_address, bus.write_address, bus.write_data);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, done, bus.read_vaild, bus.write_vaild} !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b rv=%b wv=%b required 0",
                     busy, done, bus.read_vaild, bus.write_vaild);
        end
    endtask

    task automatic test_fill();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(0, 8'h10);
        model_cmd(1'b1, 0, 2, 4, 8'hA5, -1, nw);
        run_cmd(1'b1, 0, 2, 4, 8'hA5, 0, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (to !== 1'b0 || cyc !== 6) begin
            bad++; $display("FAIL fill_latency: got cycles=%0d timeout=%b required 6", cyc, to);
        end
        total++;
        if (wv !== 4 || rv !== 0) begin
            bad++; $display("FAIL fill_vaild_cycles: got wv=%0d rv=%0d required 4 and 0", wv, rv);
        end
        total++;
        if (wr_n !== 4 || wr_addr_log[0] !== 3'd2 || wr_addr_log[1] !== 3'd3 ||
            wr_addr_log[2] !== 3'd4 || wr_addr_log[3] !== 3'd5) begin
            bad++;
            $display("FAIL fill_addresses: got n=%0d %0d,%0d,%0d,%0d required 4 beats at 2,3,4,5",
                     wr_n, wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]);
        end
        total++;
        if (count !== 4'(nw) || aborted !== 1'b0) begin
            bad++; $display("FAIL fill_status: got count=%0d aborted=%b required %0d and 0",
                            count, aborted, nw);
        end
        total++;
        if (mem_diff() !== 0) begin
            bad++; $display("FAIL fill_memory: got %0d wrong words required 0", mem_diff());
        end
    endtask

    task automatic test_copy();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(0, 8'h10);
        model_cmd(1'b0, 0, 4, 3, 8'h00, -1, nw);
        run_cmd(1'b0, 0, 4, 3, 8'h00, 0, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (mem[4] !== 8'h10 || mem[5] !== 8'h11 || mem[6] !== 8'h12 || mem_diff() !== 0) begin
            bad++; $display("FAIL copy_memory: got %h %h %h required 10 11 12",
                            mem[4], mem[5], mem[6]);
        end
        total++;
        if (to !== 1'b0 || cyc !== 8) begin
            bad++; $display("FAIL copy_latency: got cycles=%0d timeout=%b required 8", cyc, to);
        end
        total++;
        if (bd !== 1'b0 || da !== 1'b0) begin
            bad++; $display("FAIL copy_done_pulse: got busy_at_done=%b done_next=%b required 0 0",
                            bd, da);
        end
        total++;
        if (count !== 4'd3 || rv !== 3 || wv !== 3) begin
            bad++; $display("FAIL copy_count: got count=%0d rv=%0d wv=%0d required 3 3 3",
                            count, rv, wv);
        end
    endtask

    task automatic test_wrap();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(0, 8'h40);
        model_cmd(1'b1, 0, 6, 4, 8'h3C, -1, nw);
        run_cmd(1'b1, 0, 6, 4, 8'h3C, 0, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (wr_n !== 4 || wr_addr_log[0] !== 3'd6 || wr_addr_log[1] !== 3'd7 ||
            wr_addr_log[2] !== 3'd0 || wr_addr_log[3] !== 3'd1 || mem_diff() !== 0) begin
            bad++;
            $display("FAIL wrap_addresses: got n=%0d %0d,%0d,%0d,%0d diff=%0d required 6,7,0,1 diff=0",
                     wr_n, wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3],
                     mem_diff());
        end
    endtask

    task automatic test_backpressure();
        int cyc, wv, rv, nw, v0;
        logic bd, da, to;
        logic [7:0] snap [DEPTH];
        logic [3:0] cnt0;
        int diff;
        wait_cycles = 0;
        preload(0, 8'h80);
        run_cmd(1'b0, 5, 1, 6, 8'h00, 0, 0, cyc, wv, rv, bd, da, to);
        for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
        cnt0 = count;
        model_cmd(1'b0, 5, 1, 6, 8'h00, -1, nw);
        total++;
        if (mem_diff() !== 0 || cnt0 !== 4'(nw)) begin
            bad++; $display("FAIL overlap_copy: got diff=%0d count=%0d required 0 and %0d",
                            mem_diff(), cnt0, nw);
        end
        preload(0, 8'h80);
        wait_cycles = 3;
        v0 = viol;
        run_cmd(1'b0, 5, 1, 6, 8'h00, 0, 0, cyc, wv, rv, bd, da, to);
        wait_cycles = 0;
        diff = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== snap[i]) diff++;
        total++;
        if (to !== 1'b0 || diff !== 0 || count !== cnt0) begin
            bad++; $display("FAIL bp_result: got diff=%0d count=%0d timeout=%b required 0, %0d, 0",
                            diff, count, to, cnt0);
        end
        total++;
        if (wv !== 24 || rv !== 24) begin
            bad++; $display("FAIL bp_wait_cycles: got wv=%0d rv=%0d required 24 24", wv, rv);
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL bp_stability: got %0d violations required 0", viol - v0);
        end
    endtask

    task automatic test_abort();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(0, 8'h20);
        model_cmd(1'b0, 0, 3, 5, 8'h00, 2, nw);
        run_cmd(1'b0, 0, 3, 5, 8'h00, 2, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (to !== 1'b0 || wr_n !== 2 || count !== 4'd2 || aborted !== 1'b1) begin
            bad++; $display("FAIL abort_stop: got beats=%0d count=%0d aborted=%b timeout=%b required 2 2 1 0",
                            wr_n, count, aborted, to);
        end
        total++;
        if (mem_diff() !== 0) begin
            bad++; $display("FAIL abort_memory: got %0d wrong words required 0", mem_diff());
        end
        // abort while idle is ignored and the flag holds until the next start
        @(negedge clock);
        abort = 1'b1;
        repeat (3) @(negedge clock);
        abort = 1'b0;
        total++;
        if (aborted !== 1'b1 || busy !== 1'b0 || count !== 4'd2) begin
            bad++; $display("FAIL abort_hold: got aborted=%b busy=%b count=%0d required 1 0 2",
                            aborted, busy, count);
        end
    endtask

    task automatic test_length_zero();
        int cyc, wv, rv;
        logic bd, da, to;
        wait_cycles = 0;
        run_cmd(1'b0, 1, 2, 0, 8'h00, 0, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (to !== 1'b0 || cyc !== 2) begin
            bad++; $display("FAIL len0_latency: got cycles=%0d timeout=%b required 2", cyc, to);
        end
        total++;
        if (wv !== 0 || rv !== 0 || count !== 4'd0 || aborted !== 1'b0) begin
            bad++; $display("FAIL len0_no_beats: got wv=%0d rv=%0d count=%0d aborted=%b required 0",
                            wv, rv, count, aborted);
        end
    endtask

    task automatic test_clamp();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(1, 0);
        model_cmd(1'b1, 0, 3, 12, 8'h5A, -1, nw);
        run_cmd(1'b1, 0, 3, 12, 8'h5A, 0, 0, cyc, wv, rv, bd, da, to);
        total++;
        if (count !== 4'd8 || wr_n !== 8 || mem_diff() !== 0) begin
            bad++; $display("FAIL clamp: got count=%0d beats=%0d diff=%0d required 8 8 0",
                            count, wr_n, mem_diff());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        wait_cycles = 3;
        @(negedge clock);
        start = 1'b1; mode = 1'b1; dst_a = 3'd5; length = 4'd4; fill_data = 8'h77;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(count == 4'd1 && bus.write_vaild) && k < 100) begin
            @(negedge clock);
            k++;
        end
        total++;
        if (k >= 100) begin
            bad++; $display("FAIL reset_mid_reach: got count=%0d after 100 cycles required 1", count);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, aborted, count, bus.read_vaild, bus.write_vaild, bus.read_address,
             bus.write_address, bus.write_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b count=%0d wv=%b wa=%0d wd=%h required all 0",
                     busy, count, bus.write_vaild, bus.write_address, bus.write_data);
        end
        wait_cycles = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if (busy !== 1'b0 || bus.write_vaild !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle: got busy=%b wv=%b required 0 0",
                            busy, bus.write_vaild);
        end
    endtask

    task automatic test_busy_start();
        int cyc, wv, rv, nw;
        logic bd, da, to;
        wait_cycles = 0;
        preload(0, 8'h60);
        model_cmd(1'b0, 1, 5, 3, 8'h00, -1, nw);
        run_cmd(1'b0, 1, 5, 3, 8'h00, 0, 2, cyc, wv, rv, bd, da, to);
        total++;
        if (to !== 1'b0 || count !== 4'(nw) || wr_n !== 3 || mem_diff() !== 0) begin
            bad++; $display("FAIL busy_start: got count=%0d beats=%0d diff=%0d required %0d 3 0",
                            count, wr_n, mem_diff(), nw);
        end
        repeat (3) @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_start_queued: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_random();
        int cyc, wv, rv, nw, n, s, d, len, ar;
        logic bd, da, to, m, exp_ab;
        logic [7:0] f;
        for (int it = 0; it < 24; it++) begin
            preload(1, 0);
            m   = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, 7);
            d   = $urandom_range(0, 7);
            len = $urandom_range(0, 10);
            f   = 8'($urandom_range(0, 255));
            ar  = 0;
            if ($urandom_range(0, 3) == 0) begin
                ar = $urandom_range(1, 4);
                wait_cycles = 0;
            end else begin
                wait_cycles = $urandom_range(0, 2);
            end
            n = (len > DEPTH) ? DEPTH : len;
            exp_ab = (!m && ar > 0 && ar < n);
            model_cmd(m, s, d, len, f, exp_ab ? ar : -1, nw);
            run_cmd(m, s, d, len, f, ar, 0, cyc, wv, rv, bd, da, to);
            total++;
            if (to !== 1'b0 || mem_diff() !== 0 || count !== 4'(nw) || aborted !== exp_ab) begin
                bad++;
                $display("FAIL random_%0d: got diff=%0d count=%0d aborted=%b timeout=%b required 0 %0d %b 0 (m=%b s=%0d d=%0d len=%0d ar=%0d)",
                         it, mem_diff(), count, aborted, to, nw, exp_ab, m, s, d, len, ar);
            end
        end
        wait_cycles = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_backpressure();
        test_abort();
        test_length_zero();
        test_clamp();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
